// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pkg
// Shared definitions for the fetch/execute sequencer:
//   - OP_NOP / OP_HLT opcodes recognised by the sequencer itself
//   - FSM state encodings (FETCH / EXEC / HALT)
//   - default program-counter width
// -----------------------------------------------------------------------------
package fetch_sequencer_pkg;

  localparam int ADDR_W_DEF = 8;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_HLT = 8'hFF;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } fs_state_t;

endpackage

// File: rtl/fetch_sequencer_program_counter.sv
// -----------------------------------------------------------------------------
// program_counter
// Loadable, incrementing program counter. Wraps modulo 2^ADDR_W.
// Ports:
//   clk, rst   : clock / synchronous active-high reset (pc -> 0)
//   inc        : advance pc by one
//   load       : replace pc with loadVal (takes priority over inc)
//   loadVal    : load value
//   pc         : current program counter
// -----------------------------------------------------------------------------
module program_counter
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] loadVal,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_next;

  always_comb begin
    pc_next = pc_reg;
    if (load) begin
      pc_next = loadVal;
    end else if (inc) begin
      // Natural overflow of the ADDR_W-bit add gives the wrap to zero.
      pc_next = pc_reg + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= '0;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Fetch/execute sequencer feeding a control unit one instruction at a time.
// Owns the PC (via program_counter), the instruction register and the
// per-instruction step counter; handles jumps and the halt opcode.
// Ports:
//   clk, rst          : clock / synchronous active-high reset
//   memRd, memAddr    : fetch request and address (current pc)
//   memRdy, memData   : memory response (qualified only while memRd=1)
//   inst, instValid   : instruction register and execute-phase flag
//   step              : 0-based execute-cycle index
//   execDone          : control unit signals last step of instruction
//   jmpEn, jmpAddr    : jump request, honoured only on the completing cycle
//   halted            : halt opcode has executed; only rst leaves this state
// All outputs come straight from registers or decode of registered state.
// -----------------------------------------------------------------------------
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MAX_STEPS = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              memRd,
  output logic [ADDR_W-1:0] memAddr,
  input  logic              memRdy,
  input  logic [7:0]        memData,
  output logic [7:0]        inst,
  output logic              instValid,
  output logic [1:0]        step,
  input  logic              execDone,
  input  logic              jmpEn,
  input  logic [ADDR_W-1:0] jmpAddr,
  output logic              halted
);

  localparam logic [1:0] LAST_STEP = 2'(MAX_STEPS - 1);

  fs_state_t         state_reg, state_next;
  logic [7:0]        inst_reg, inst_next;
  logic [1:0]        step_reg, step_next;
  logic              memrd_reg, memrd_next;
  logic              pc_inc;
  logic              pc_load;
  logic              exec_complete;
  logic [ADDR_W-1:0] pc;

  program_counter #(
    .ADDR_W (ADDR_W)
  ) u_pc (
    .clk     (clk),
    .rst     (rst),
    .inc     (pc_inc),
    .load    (pc_load),
    .loadVal (jmpAddr),
    .pc      (pc)
  );

  // NOP and HLT are single-cycle regardless of what the control unit says.
  assign exec_complete = execDone
                      || (step_reg == LAST_STEP)
                      || (inst_reg == OP_NOP)
                      || (inst_reg == OP_HLT);

  always_comb begin
    state_next = state_reg;
    inst_next  = inst_reg;
    step_next  = step_reg;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;

    case (state_reg)
      FETCH: begin
        // memRdy only counts while the request is actually on the bus; this
        // also discards a response presented in the idle cycle after reset.
        if (memrd_reg && memRdy) begin
          inst_next  = memData;
          step_next  = 2'd0;
          pc_inc     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (exec_complete) begin
          step_next = 2'd0;
          if (inst_reg == OP_HLT) begin
            state_next = HALT;
          end else begin
            state_next = FETCH;
            pc_load    = jmpEn;
          end
        end else begin
          step_next = step_reg + 2'd1;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // The fetch request is a register so it is low while reset is applied and
  // rises on the first clock edge after reset is released.
  assign memrd_next = (state_next == FETCH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= FETCH;
      inst_reg  <= OP_NOP;
      step_reg  <= 2'd0;
      memrd_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      inst_reg  <= inst_next;
      step_reg  <= step_next;
      memrd_reg <= memrd_next;
    end
  end

  assign memRd     = memrd_reg;
  assign memAddr   = pc;
  assign inst      = inst_reg;
  assign instValid = (state_reg == EXEC);
  assign step      = step_reg;
  assign halted    = (state_reg == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed stimulus with a scoreboard: every cycle in which the DUT is
// expected to present something (fetch request, execute phase or halted),
// the stimulus pushes the expected output vector; a monitor on the falling
// edge pops and compares whenever the DUT actually presents an output.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  typedef struct packed {
    logic       rd;
    logic [7:0] addr;
    logic       iv;
    logic [7:0] inst;
    logic [1:0] step;
    logic       hlt;
  } obs_t;

  logic       clk;
  logic       rst;
  logic       memRd;
  logic [7:0] memAddr;
  logic       memRdy;
  logic [7:0] memData;
  logic [7:0] inst;
  logic       instValid;
  logic [1:0] step;
  logic       execDone;
  logic       jmpEn;
  logic [7:0] jmpAddr;
  logic       halted;

  int total;
  int bad;
  int txn;
  obs_t exp_q[$];

  fetch_sequencer #(
    .ADDR_W    (8),
    .MAX_STEPS (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .memRd     (memRd),
    .memAddr   (memAddr),
    .memRdy    (memRdy),
    .memData   (memData),
    .inst      (inst),
    .instValid (instValid),
    .step      (step),
    .execDone  (execDone),
    .jmpEn     (jmpEn),
    .jmpAddr   (jmpAddr),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t f_fetch(input logic [7:0] a, input logic [7:0] i);
    obs_t o;
    o = '{rd: 1'b1, addr: a, iv: 1'b0, inst: i, step: 2'd0, hlt: 1'b0};
    return o;
  endfunction

  function automatic obs_t f_exec(input logic [7:0] a, input logic [7:0] i,
                                  input logic [1:0] s);
    obs_t o;
    o = '{rd: 1'b0, addr: a, iv: 1'b1, inst: i, step: s, hlt: 1'b0};
    return o;
  endfunction

  function automatic obs_t f_halt(input logic [7:0] a, input logic [7:0] i);
    obs_t o;
    o = '{rd: 1'b0, addr: a, iv: 1'b0, inst: i, step: 2'd0, hlt: 1'b1};
    return o;
  endfunction

  // Monitor: one line per presented transaction.
  always @(negedge clk) begin
    obs_t got;
    obs_t want;
    got = '{rd: memRd, addr: memAddr, iv: instValid, inst: inst,
            step: step, hlt: halted};
    if ((memRd === 1'b1) || (instValid === 1'b1) || (halted === 1'b1)) begin
      total++;
      txn++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_txn%0d got rd=%b addr=%h iv=%b inst=%h step=%0d hlt=%b (nothing expected)",
                 txn, got.rd, got.addr, got.iv, got.inst, got.step, got.hlt);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          bad++;
          $display("FAIL txn%0d got rd=%b addr=%h iv=%b inst=%h step=%0d hlt=%b want rd=%b addr=%h iv=%b inst=%h step=%0d hlt=%b",
                   txn, got.rd, got.addr, got.iv, got.inst, got.step, got.hlt,
                   want.rd, want.addr, want.iv, want.inst, want.step, want.hlt);
        end else begin
          $display("txn%0d ok rd=%b addr=%h iv=%b inst=%h step=%0d hlt=%b",
                   txn, got.rd, got.addr, got.iv, got.inst, got.step, got.hlt);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end else begin
      $display("check %s ok value=%h", name, act);
    end
  endtask

  // Called just after a rising edge: drive this cycle's inputs, register the
  // expected presentation (if any), then advance to just after the next edge.
  task automatic tick(input logic rdy, input logic [7:0] data, input logic done,
                      input logic jen, input logic [7:0] jaddr,
                      input bit act, input obs_t e);
    memRdy   = rdy;
    memData  = data;
    execDone = done;
    jmpEn    = jen;
    jmpAddr  = jaddr;
    if (act) exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    obs_t none;
    none     = '0;
    total    = 0;
    bad      = 0;
    txn      = 0;
    rst      = 1'b1;
    memRdy   = 1'b1;
    memData  = 8'hFF;
    execDone = 1'b0;
    jmpEn    = 1'b0;
    jmpAddr  = 8'h00;

    // Reset held for two edges with a halt opcode offered on the bus.
    @(posedge clk); #1;
    chk("rst_memrd", {7'b0, memRd}, 8'h00);
    chk("rst_inst", inst, 8'h00);
    chk("rst_halted", {7'b0, halted}, 8'h00);
    chk("rst_instvalid", {7'b0, instValid}, 8'h00);
    @(posedge clk); #1;
    chk("rst2_memrd", {7'b0, memRd}, 8'h00);
    chk("rst2_step", {6'b0, step}, 8'h00);
    rst = 1'b0;
    // Release edge: memRdy=1 / memData=FF must not be captured.
    tick(1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, none);
    chk("post_rst_memrd", {7'b0, memRd}, 8'h01);
    chk("post_rst_memaddr", memAddr, 8'h00);

    // NOP then 8'b00001_011 ending on step 1 via execDone.
    tick(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, f_fetch(8'h00, 8'h00));
    tick(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, f_exec(8'h01, 8'h00, 2'd0));
    tick(1'b1, 8'h0B, 1'b0, 1'b0, 8'h00, 1'b1, f_fetch(8'h01, 8'h00));
    tick(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, f_exec(8'h02, 8'h0B, 2'd0));
    tick(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, f_exec(8'h02, 8'h0B, 2'd1));

    // Three wait cycles on the fetch at address 2, then 8'h01 arrives.
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 8'h55, 1'b0, 1'b0, 8'h00, 1'b1, f_fetch(8'h02, 8'h0B));
    end
    tick(1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, f_fetch(8'h02, 8'h0B));

    // No execDone: forced completion on step 3; jump on step 2 ignored.
    tick(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, f_exec(8'h03, 8'h01, 2'd0));
    tick(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, f_exec(8'h03, 8'h01, 2'd1));
    tick(1'b0, 8'h00, 1'b0, 1'b1, 8'h40, 1'b1, f_exec(8'h03, 8'h01, 2'd2));
    tick(1'b0, 8'h00, 1'b0, 1'b1, 8'h40, 1'b1, f_exec(8'h03, 8'h01, 2'd3));

    // Fetch at 40, jump to FF, fetch there, next fetch address wraps to 00.
    tick(1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 1'b1, f_fetch(8'h40, 8'h01));
    tick(1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, f_exec(8'h41, 8'h02, 2'd0));
    tick(1'b1, 8'h03, 1'b0, 1'b0, 8'h00, 1'b1, f_fetch(8'hFF, 8'h02));
    tick(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, f_exec(8'h00, 8'h03, 2'd0));

    // Halt opcode fetched at 00; jump on its execute cycle is ignored.
    tick(1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b1, f_fetch(8'h00, 8'h03));
    tick(1'b0, 8'h00, 1'b0, 1'b1, 8'h40, 1'b1, f_exec(8'h01, 8'hFF, 2'd0));
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 8'h00, 1'b1, 1'b1, 8'h20, 1'b1, f_halt(8'h01, 8'hFF));
    end

    // Single-cycle reset pulse out of HALT.
    rst = 1'b1;
    tick(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, f_halt(8'h01, 8'hFF));
    rst = 1'b0;
    chk("halt_rst_halted", {7'b0, halted}, 8'h00);
    chk("halt_rst_memrd", {7'b0, memRd}, 8'h00);
    chk("halt_rst_inst", inst, 8'h00);
    tick(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, none);
    tick(1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 1'b1, f_fetch(8'h00, 8'h00));
    tick(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, f_exec(8'h01, 8'h05, 2'd0));

    // Reset asserted mid-execute, with a jump and a response also offered.
    rst = 1'b1;
    tick(1'b1, 8'h77, 1'b1, 1'b1, 8'h40, 1'b1, f_exec(8'h01, 8'h05, 2'd1));
    rst = 1'b0;
    chk("exec_rst_instvalid", {7'b0, instValid}, 8'h00);
    chk("exec_rst_inst", inst, 8'h00);
    chk("exec_rst_step", {6'b0, step}, 8'h00);
    chk("exec_rst_memaddr", memAddr, 8'h00);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, none);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, f_fetch(8'h00, 8'h00));
    tick(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, f_fetch(8'h00, 8'h00));

    chk("scoreboard_drained", 8'(exp_q.size()), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
